// File: rtl/audio_pkg.sv
// Shared audio-path definitions: ADC frame geometry and the serial transfer state enum
// used by the ADC capture engine (and later the DAC transmitter).
package audio_pkg;

  localparam int ADC_BITS  = 14;
  localparam int ADC_FRAME = 34;
  localparam int CH0_FIRST = 2;
  localparam int CH1_FIRST = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } xfer_state_t;

  // True when SCK index idx carries one of the ADC_BITS data bits of a channel starting at first.
  function automatic logic in_window(input logic [5:0] idx, input logic [5:0] first);
    return (idx >= first) && (idx < (first + 6'(ADC_BITS)));
  endfunction

endpackage

// File: rtl/adc_lector_sck_gen.sv
// SPI clock generator: each SCK half lasts CLKDIV system clocks, starting with the high half.
// Held cleared (SCK low, counter zero) whenever i_run is low or i_halt is high.
module sck_gen #(
  parameter int CLKDIV = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_run,
  input  logic i_halt,
  output logic o_rise_en,
  output logic o_fall_en,
  output logic o_spi_sck
);

  localparam logic [7:0] SCK_LAST = 8'(CLKDIV - 1);

  logic [7:0] r_cnt;
  logic       r_sck;
  logic       w_toggle;

  // A toggle is due on the first clock of every half period.
  assign w_toggle  = i_run && (r_cnt == 8'd0);
  assign o_rise_en = w_toggle && !r_sck;
  assign o_fall_en = w_toggle && r_sck;
  assign o_spi_sck = r_sck;

  // Half-period counter and registered SCK.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= 8'd0;
      r_sck <= 1'b0;
    end else if (!i_run || i_halt) begin
      r_cnt <= 8'd0;
      r_sck <= 1'b0;
    end else begin
      if (r_cnt == SCK_LAST) begin
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_toggle) begin
        r_sck <= !r_sck;
      end
    end
  end

endmodule

// File: rtl/adc_lector.sv
// LTC1407A capture engine: while granted, pulses AD_CONV, clocks a 34-bit SPI frame and
// publishes the two 14-bit two's-complement samples with a one-cycle valid strobe.
module adc_lector
  import audio_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                enableadc,
  input  logic                spi_miso,
  output logic                ad_conv,
  output logic                spi_sck,
  output logic [ADC_BITS-1:0] sample_ch0,
  output logic [ADC_BITS-1:0] sample_ch1,
  output logic                valid,
  output logic                busy
);

  localparam logic [8:0] CONV_LAST = 9'(2 * CLKDIV - 1);

  xfer_state_t         r_state;
  logic [8:0]          r_conv_cnt;
  logic [5:0]          r_bit;
  logic [ADC_BITS-1:0] r_sh0;
  logic [ADC_BITS-1:0] r_sh1;

  logic w_conv_last;
  logic w_run;
  logic w_rise_en;
  logic w_fall_en;
  logic w_frame_end;

  // SCK starts on the edge that leaves CONV so the frame occupies exactly 68*CLKDIV clocks.
  assign w_conv_last = (r_state == ST_CONV) && (r_conv_cnt == CONV_LAST);
  assign w_run       = enableadc && ((r_state == ST_SHIFT) || w_conv_last);
  assign w_frame_end = (r_state == ST_SHIFT) && w_rise_en && (r_bit == 6'(ADC_FRAME));

  sck_gen #(
    .CLKDIV (CLKDIV)
  ) u_sck_gen (
    .clock     (clock),
    .resetn    (resetn),
    .i_run     (w_run),
    .i_halt    (w_frame_end),
    .o_rise_en (w_rise_en),
    .o_fall_en (w_fall_en),
    .o_spi_sck (spi_sck)
  );

  // Transfer FSM with registered ad_conv/valid/busy; samples load on the edge into DONE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_conv_cnt <= 9'd0;
      ad_conv    <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      sample_ch0 <= '0;
      sample_ch1 <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          valid <= 1'b0;
          if (enableadc) begin
            r_state    <= ST_CONV;
            r_conv_cnt <= 9'd0;
            ad_conv    <= 1'b1;
            busy       <= 1'b1;
          end else begin
            ad_conv <= 1'b0;
            busy    <= 1'b0;
          end
        end
        ST_CONV: begin
          if (!enableadc) begin
            r_state <= ST_IDLE;
            ad_conv <= 1'b0;
            busy    <= 1'b0;
          end else if (w_conv_last) begin
            r_state <= ST_SHIFT;
            ad_conv <= 1'b0;
          end else begin
            r_conv_cnt <= r_conv_cnt + 9'd1;
          end
        end
        ST_SHIFT: begin
          if (!enableadc) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else if (w_frame_end) begin
            r_state    <= ST_DONE;
            valid      <= 1'b1;
            sample_ch0 <= r_sh0;
            sample_ch1 <= r_sh1;
          end
        end
        ST_DONE: begin
          valid <= 1'b0;
          if (enableadc) begin
            r_state    <= ST_CONV;
            r_conv_cnt <= 9'd0;
            ad_conv    <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          ad_conv <= 1'b0;
          valid   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // SCK index counter and per-channel deserialisers; MISO taken on each SCK rise.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_bit <= 6'd0;
      r_sh0 <= '0;
      r_sh1 <= '0;
    end else if ((r_state == ST_IDLE) || (r_state == ST_DONE)) begin
      r_bit <= 6'd0;
    end else begin
      if (w_fall_en) begin
        r_bit <= r_bit + 6'd1;
      end
      if (w_rise_en && in_window(r_bit, 6'(CH0_FIRST))) begin
        r_sh0 <= {r_sh0[ADC_BITS-2:0], spi_miso};
      end
      if (w_rise_en && in_window(r_bit, 6'(CH1_FIRST))) begin
        r_sh1 <= {r_sh1[ADC_BITS-2:0], spi_miso};
      end
    end
  end

endmodule

// File: tb/tb_adc_lector.sv
// Self-checking bench for adc_lector: three instances (CLKDIV 2, 1, 5) driven by an LTC1407A
// MISO model; expected samples go through a scoreboard queue and are popped on valid.
module tb_adc_lector;

  typedef struct packed {
    logic [13:0] c0;
    logic [13:0] c1;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic [2:0]  en;
  logic [2:0]  miso;
  logic [2:0]  adc;
  logic [2:0]  sck;
  logic [2:0]  vld;
  logic [2:0]  bsy;
  logic [13:0] s0 [3];
  logic [13:0] s1 [3];

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        sb[$];
  logic [13:0] d0 [4];
  logic [13:0] d1 [4];
  logic [33:0] junk;

  always #5 clock = ~clock;

  adc_lector #(.CLKDIV(2)) u_c2 (
    .clock(clock), .resetn(resetn), .enableadc(en[0]), .spi_miso(miso[0]),
    .ad_conv(adc[0]), .spi_sck(sck[0]), .sample_ch0(s0[0]), .sample_ch1(s1[0]),
    .valid(vld[0]), .busy(bsy[0]));

  adc_lector #(.CLKDIV(1)) u_c1 (
    .clock(clock), .resetn(resetn), .enableadc(en[1]), .spi_miso(miso[1]),
    .ad_conv(adc[1]), .spi_sck(sck[1]), .sample_ch0(s0[1]), .sample_ch1(s1[1]),
    .valid(vld[1]), .busy(bsy[1]));

  adc_lector #(.CLKDIV(5)) u_c5 (
    .clock(clock), .resetn(resetn), .enableadc(en[2]), .spi_miso(miso[2]),
    .ad_conv(adc[2]), .spi_sck(sck[2]), .sample_ch0(s0[2]), .sample_ch1(s1[2]),
    .valid(vld[2]), .busy(bsy[2]));

  // Bit the ADC presents for SCK index idx: ch0 MSB-first at 2..15, ch1 at 18..31, junk elsewhere.
  function automatic logic fbit(input logic [13:0] a, input logic [13:0] b,
                                input logic [33:0] j, input int idx);
    if (idx >= 2 && idx <= 15) return a[15-idx];
    if (idx >= 18 && idx <= 31) return b[31-idx];
    if (idx >= 0 && idx <= 33) return j[idx];
    return 1'b0;
  endfunction

  // Grants instance sel for nfr back-to-back frames from d0/d1; call on a negedge.
  task automatic run_grant(input int sel, input int c, input int nfr);
    int   rises, adc_hi, f, period, limit;
    logic prev_sck;
    bit   want_conv;
    exp_t e;
    for (int k = 0; k < nfr; k++) sb.push_back('{c0: d0[k], c1: d1[k]});
    rises = 0; adc_hi = 0; f = 0; prev_sck = 1'b0; want_conv = 1'b0;
    period = 70 * c + 1;
    limit  = nfr * period + 20;
    miso[sel] = fbit(d0[0], d1[0], junk, 0);
    en[sel] = 1'b1;
    for (int i = 1; i <= limit && f < nfr; i++) begin
      @(negedge clock);
      if (want_conv) begin
        n_checks++;
        if (adc[sel] !== 1'b1) $display("FAIL conv_after_valid: ad_conv=%b expected 1", adc[sel]);
        else n_pass++;
        want_conv = 1'b0;
      end
      if (sck[sel] && !prev_sck) rises++;
      prev_sck = sck[sel];
      if (adc[sel]) adc_hi++;
      if (vld[sel]) begin
        n_checks++;
        if (i != (f + 1) * period) $display("FAIL valid_cycle: valid at k+%0d expected k+%0d", i, (f + 1) * period);
        else n_pass++;
        n_checks++;
        if (rises != 34) $display("FAIL sck_rises: %0d rises expected 34", rises);
        else n_pass++;
        n_checks++;
        if (adc_hi != 2 * c) $display("FAIL ad_conv_width: %0d clocks expected %0d", adc_hi, 2 * c);
        else n_pass++;
        n_checks++;
        if (bsy[sel] !== 1'b1) $display("FAIL busy_at_valid: busy=%b expected 1", bsy[sel]);
        else n_pass++;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_valid: valid with empty scoreboard expected none");
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (s0[sel] !== e.c0) $display("FAIL sample_ch0: got %h expected %h", s0[sel], e.c0);
          else n_pass++;
          n_checks++;
          if (s1[sel] !== e.c1) $display("FAIL sample_ch1: got %h expected %h", s1[sel], e.c1);
          else n_pass++;
        end
        f++; rises = 0; adc_hi = 0;
        if (f == nfr) en[sel] = 1'b0;
        else want_conv = 1'b1;
      end
      miso[sel] = (f < nfr) ? fbit(d0[f], d1[f], junk, rises) : 1'b0;
    end
    n_checks++;
    if (f != nfr) $display("FAIL frames_done: %0d frames expected %0d", f, nfr);
    else n_pass++;
    en[sel] = 1'b0;
    sb.delete();
    repeat (3) @(negedge clock);
    n_checks++;
    if ({bsy[sel], vld[sel], adc[sel], sck[sel]} !== 4'b0000)
      $display("FAIL idle_after: busy/valid/conv/sck=%b expected 0000", {bsy[sel], vld[sel], adc[sel], sck[sel]});
    else n_pass++;
  endtask

  task automatic test_reset();
    resetn = 1'b0; en = 3'b000; miso = 3'b000; junk = 34'h0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({adc, sck, vld, bsy} !== 12'h000) $display("FAIL reset_ctrl: got %h expected 000", {adc, sck, vld, bsy});
    else n_pass++;
    n_checks++;
    if ({s0[0], s1[0], s0[1], s1[1], s0[2], s1[2]} !== 84'h0)
      $display("FAIL reset_samples: got %h %h expected 0", s0[0], s1[0]);
    else n_pass++;
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if (bsy !== 3'b000) $display("FAIL idle_no_grant: busy=%b expected 000", bsy);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    d0[0] = 14'h1ABC; d1[0] = 14'h2345; junk = 34'h0;
    run_grant(0, 2, 1);
  endtask

  task automatic test_sign_and_ignored();
    d0[0] = 14'h2000; d1[0] = 14'h1FFF; junk = 34'h3_0003_0003;
    run_grant(0, 2, 1);
  endtask

  task automatic test_back_to_back();
    d0[0] = 14'h0123; d1[0] = 14'h3210;
    d0[1] = 14'h2AAA; d1[1] = 14'h1555;
    d0[2] = 14'h0F0F; d1[2] = 14'h30C3;
    junk = 34'h2_AAAA_AAAA;
    run_grant(0, 2, 3);
  endtask

  task automatic test_abort();
    int   rises, nvalid;
    logic prev_sck;
    bit   dropped;
    rises = 0; nvalid = 0; prev_sck = 1'b0; dropped = 1'b0;
    miso[0] = 1'b1; en[0] = 1'b1;
    for (int i = 0; i < 400 && !dropped; i++) begin
      @(negedge clock);
      if (sck[0] && !prev_sck) rises++;
      prev_sck = sck[0];
      if (rises == 11) begin
        en[0] = 1'b0;
        dropped = 1'b1;
      end
    end
    n_checks++;
    if (!dropped) $display("FAIL abort_reach: reached %0d rises expected 11", rises);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if ({sck[0], bsy[0], adc[0], vld[0]} !== 4'b0000)
      $display("FAIL abort_ctrl: sck/busy/conv/valid=%b expected 0000", {sck[0], bsy[0], adc[0], vld[0]});
    else n_pass++;
    n_checks++;
    if (s0[0] !== d0[2] || s1[0] !== d1[2])
      $display("FAIL abort_hold: got %h/%h expected %h/%h", s0[0], s1[0], d0[2], d1[2]);
    else n_pass++;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (vld[0]) nvalid++;
    end
    n_checks++;
    if (nvalid != 0) $display("FAIL abort_no_valid: %0d valids expected 0", nvalid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    int   rises;
    logic prev_sck;
    rises = 0; prev_sck = 1'b0;
    miso[0] = 1'b1; en[0] = 1'b1;
    for (int i = 0; i < 400 && rises < 5; i++) begin
      @(negedge clock);
      if (sck[0] && !prev_sck) rises++;
      prev_sck = sck[0];
    end
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({sck[0], bsy[0], adc[0], vld[0]} !== 4'b0000 || rises < 5)
      $display("FAIL rst_mid_ctrl: sck/busy/conv/valid=%b rises=%0d expected 0000 after 5", {sck[0], bsy[0], adc[0], vld[0]}, rises);
    else n_pass++;
    n_checks++;
    if (s0[0] !== 14'h0 || s1[0] !== 14'h0)
      $display("FAIL rst_mid_samples: got %h/%h expected 0000/0000", s0[0], s1[0]);
    else n_pass++;
    @(negedge clock);
    resetn = 1'b1;
    d0[0] = 14'h3ACE; d1[0] = 14'h0BD1; junk = 34'h1_5555_5555;
    run_grant(0, 2, 1);
  endtask

  task automatic test_clkdiv();
    d0[0] = 14'h0F0F; d1[0] = 14'h3C3C; junk = 34'h3_0003_0003;
    run_grant(1, 1, 1);
    d0[0] = 14'h2468; d1[0] = 14'h1357; junk = 34'h0;
    run_grant(2, 5, 1);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_sign_and_ignored();
    test_back_to_back();
    test_abort();
    test_reset_mid_shift();
    test_clkdiv();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_lector.md
# adc_lector

Capture engine for the LTC1407A dual-channel ADC on the shared starter-kit SPI bus. It responds to the ADC grant (`enableadc`) issued by `controlador`. While granted, it drives the AD_CONV pulse and SPI_SCK, and deserialises SPI_MISO into two 14-bit two's-complement samples. It then returns a one-cycle `valid` to the audio datapath.

## Interface
Parameters:
- `CLKDIV`, default 2: system clocks per SCK half-period (50 MHz → 12.5 MHz SCK); legal range 1..255.

Ports:
- `clock`  in  1: system clock; all logic on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `enableadc`  in  1: grant from `controlador`; level-sensitive, high = bus owned by ADC.
- `spi_miso`  in  1: ADC serial data, MSB first.
- `ad_conv`  out  1: conversion start pulse to ADC.
- `spi_sck`  out  1: serial clock; idle low.
- `sample_ch0`  out  14: last completed channel-0 sample, two's complement.
- `sample_ch1`  out  14: last completed channel-1 sample, two's complement.
- `valid`  out  1: one-cycle strobe; samples updated this cycle.
- `busy`  out  1: high from grant acceptance until `valid`, inclusive.

## Operation
- States: IDLE, CONV, SHIFT, DONE.
- Reset values: state IDLE, `ad_conv` 0, `spi_sck` 0, `sample_ch0`/`sample_ch1` 0, `valid` 0, `busy` 0, all counters 0.
- IDLE → CONV when `enableadc`=1.
  - In CONV: `ad_conv`=1 for 2·CLKDIV clocks, `spi_sck`=0.
  - Then → SHIFT.
- SHIFT runs the 34-cycle frame.
  - Each SCK period is one rising half followed by one falling half, each CLKDIV clocks.
  - MISO is sampled on the clock where `spi_sck` goes 0→1.
- Frame bit map, by SCK index 0..33:
  - 0–1: ignored.
  - 2–15: ch0 b13..b0.
  - 16–17: ignored.
  - 18–31: ch1 b13..b0.
  - 32–33: ignored.
- Shift registers are internal. The output sample registers load only in DONE, so a partial frame is never visible on the outputs.
- After SCK index 33 completes (`spi_sck` back low) → DONE.
  - DONE lasts one clock: `valid`=1, outputs loaded.
  - Then → CONV if `enableadc`=1 (back-to-back frames), else → IDLE.
- Abort: if `enableadc`=0 in CONV or SHIFT, go to IDLE next clock.
  - `ad_conv` and `spi_sck` are forced 0 in that same next clock.
  - No `valid`; outputs keep the previous sample.
- `busy` = (state ≠ IDLE).

## Timing
- Latency: `enableadc` sampled high at edge k → `ad_conv` high at k+1.
- `valid` high during cycle k+1+2·CLKDIV+68·CLKDIV, i.e. k+141 for CLKDIV=2.
- Continuous grant frame period: 70·CLKDIV+1 clocks (141).
- `spi_sck`, `ad_conv` and `valid` are registered outputs with no combinational path from inputs.
- `resetn` asserted mid-frame: all outputs reach reset values immediately (asynchronous). The first post-release frame starts only on a fresh `enableadc` sample.
- `enableadc` rising in DONE's own cycle is irrelevant; only the level sampled in DONE decides the next state.
- With CLKDIV=1, SCK = clock/2; the bit map is unchanged.

## Structure
- Shared package `audio_pkg` holds:
  - `ADC_BITS`=14 and `ADC_FRAME`=34;
  - bit-index constants CH0_FIRST=2 and CH1_FIRST=18;
  - the state enum, also reused by the future DAC transmitter.
- One sub-module: `sck_gen`.
  - Divide-by-CLKDIV counter.
  - Outputs `rise_en`, `fall_en` and the registered `spi_sck`.
  - Held cleared while not in SHIFT.
- The FSM, bit counter (0..33) and shift registers stay in `adc_lector`.

## Test plan
- Single frame, CLKDIV=2, MISO model returns ch0=14'h1ABC, ch1=14'h2345 → one `valid` at k+141, `sample_ch0`=14'h1ABC, `sample_ch1`=14'h2345, exactly 34 SCK rising edges, `ad_conv` high 4 clocks.
- Sign check: ch0=14'h2000 (−8192), ch1=14'h1FFF → `sample_ch0`=14'h2000, `sample_ch1`=14'h1FFF; MISO toggling in ignored slots 0,1,16,17,32,33 has no effect.
- Continuous grant for 3 frames with distinct data → `valid` every 141 clocks, each frame's samples correct, `ad_conv` re-asserted the clock after each `valid`.
- Grant dropped at SCK index 10 → next clock IDLE, `spi_sck`=0, no `valid`, outputs keep prior frame values, `busy` falls.
- `resetn` pulsed low mid-SHIFT → outputs zero asynchronously; after release with grant high, a full clean frame completes at +141.
- CLKDIV=1 and CLKDIV=5 → `valid` at k+71 and k+351 respectively, data correct.
